math_solver: RTL and testbench
==============================

// Module: math_solver
// PURPOSE
//  Evaluates an integer infix expression held as a packed token array. Conversion uses
//  shunting-yard: infix -> postfix, one token per cycle. A stack-based ALU then evaluates
//  the postfix string. Standalone arithmetic accelerator; debug ports expose every ALU step.
// PARAMETERS
//  N  19  max token count of infix/postfix arrays (operand/op stack depth = N)
//  W  16  token/data width in bits; operands are W-bit two's complement
// PORTS
//  CLK          in   1          single clock, rising edge
//  RST          in   1          asynchronous, active-high reset
//  start        in   1          1-cycle pulse: latch infix, begin solve
//  infix        in   [1:0][N-1:0][W-1:0]  [0][i]=value, [1][i]=flag (0 operand, 1 operator)
//  postfix      out  [1:0][N-1:0][W-1:0]  converted string, same encoding
//  result       out  W          signed result, valid when done=1
//  done         out  1          high from completion until next start
//  error        out  1          high with done on malformed expression
//  input_data   out  W          operand pushed on current ALU step
//  opcode       out  3          current ALU opcode
//  first        out  W          left operand popped (second-from-top)
//  second       out  W          right operand popped (top)
//  output_data  out  W          value pushed back by ALU op
// BEHAVIOUR
//  Reset (async): state IDLE; result, postfix, debug outputs, done, error = 0.
//  Operator codes (ASCII): '('=40 ')'=41 '*'=42 '+'=43 '-'=45 '/'=47. Flag=1, value=0 is END.
//  Precedence: * / = 2, + - = 1; left-associative; parentheses dropped from postfix.
//  FSM: IDLE -start-> CONVERT (token i per cycle, i=0..N-1; stop early at END)
//   -> FLUSH (pop one op/cycle to postfix) -> EVAL (one postfix token/cycle) -> DONE.
//  DONE holds outputs until next start. start outside IDLE/DONE is ignored.
//  Unused postfix slots = flag 1, value 0.
//  Worst-case latency <= 3N+2 cycles from start to done.
//  ALU opcodes: 000 NOP, 001 ADD, 010 SUB, 011 MUL, 100 DIV, 110 PUSH; others reserved (NOP).
//  Arithmetic: mod 2^W wrap. MUL keeps low W bits. DIV is signed, truncates toward 0.
//   x/0 -> 0, error=1.
//  Errors -> result=0, error=1, done=1:
//   - unmatched ( or )
//   - operator with <2 stack operands
//   - final stack depth != 1
//   - unknown operator code
//  Empty expression (token 0 = END) -> result 0, error 1.
// CONFIGURATION
//  MATHSOLVER_DIV_EN defined: '/' (47) and DIV opcode supported.
//  Undefined: token 47 is an unknown operator (error), and opcode 100 is never issued.
// STRUCTURE
//  Package math_solver_pkg: token codes, precedence function, opcode enum, FSM state enum.
//  Sub-module stack_alu: operand stack with push/op interface; drives first/second/output_data.
// TESTING
//  1) Tokens 2*3+(10+4+3)*-20+(6+5), N=19, W=16 -> postfix 2 3 * 10 4 + 3 + -20 * + 6 5 + +
//     plus 4 END slots; result = -323 (16'hFEBD); error=0.
//  2) 7-2-3 -> postfix 7 2 - 3 -; result 2 (left associativity).
//  3) 300*300 -> result 16'h5F90 (wrap, low 16 bits of 90000); error=0.
//  4) (1+2 -> done=1, error=1, result 0; likewise 1+ -> error=1.
//  5) With MATHSOLVER_DIV_EN: -7/2 -> -3; 5/0 -> result 0, error=1.
//     Without MATHSOLVER_DIV_EN: 6/2 -> error=1.
//  6) Assert RST mid-EVAL -> all outputs 0 immediately.
//     Then start with test 1 -> -323 again.

Source files
------------

// File: rtl/math_solver_pkg.sv
// ============================================================================
//  Module      : math_solver_pkg
//  Description : Token codes, precedence, ALU opcodes and FSM states shared
//                by the math_solver infix-to-postfix evaluator.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package math_solver_pkg;

    localparam logic [7:0] TOK_END = 8'd0;
    localparam logic [7:0] TOK_LP  = 8'd40;
    localparam logic [7:0] TOK_RP  = 8'd41;
    localparam logic [7:0] TOK_MUL = 8'd42;
    localparam logic [7:0] TOK_ADD = 8'd43;
    localparam logic [7:0] TOK_SUB = 8'd45;
    localparam logic [7:0] TOK_DIV = 8'd47;

    typedef enum logic [2:0] {
        OPC_NOP  = 3'b000,
        OPC_ADD  = 3'b001,
        OPC_SUB  = 3'b010,
        OPC_MUL  = 3'b011,
        OPC_DIV  = 3'b100,
        OPC_PUSH = 3'b110
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CONVERT = 3'd1,
        ST_FLUSH   = 3'd2,
        ST_EVAL    = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    function automatic logic [1:0] prec(input logic [7:0] code);
        case (code)
            TOK_MUL, TOK_DIV: prec = 2'd2;
            TOK_ADD, TOK_SUB: prec = 2'd1;
            default:          prec = 2'd0;
        endcase
    endfunction

    function automatic opcode_e tok2opc(input logic [7:0] code);
        case (code)
            TOK_ADD: tok2opc = OPC_ADD;
            TOK_SUB: tok2opc = OPC_SUB;
            TOK_MUL: tok2opc = OPC_MUL;
            TOK_DIV: tok2opc = OPC_DIV;
            default: tok2opc = OPC_NOP;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/stack_alu.sv
// ============================================================================
//  Module      : stack_alu
//  Description : Operand stack with push / binary-op interface; registers the
//                operands and result of every step for debug visibility.
//                Macro MATHSOLVER_DIV_EN enables the signed DIV opcode.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module stack_alu
    import math_solver_pkg::*;
#(
    parameter int N  = 19,
    parameter int W  = 16,
    parameter int DW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_valid,
    input  opcode_e       i_opcode,
    input  logic [W-1:0]  i_data,
    output logic [DW-1:0] o_depth,
    output logic [W-1:0]  o_top,
    output logic [W-1:0]  o_input_data,
    output logic [2:0]    o_opcode,
    output logic [W-1:0]  o_first,
    output logic [W-1:0]  o_second,
    output logic [W-1:0]  o_output_data
);

    logic [W-1:0]  r_stk [N];
    logic [DW-1:0] r_depth;
    logic [W-1:0]  r_in, r_first, r_second, r_out;
    logic [2:0]    r_opc;
    logic [W-1:0]  w_a, w_b, w_res;
    logic          w_div_op, w_binop, w_push;

    assign w_b     = r_stk[r_depth - DW'(1)];
    assign w_a     = r_stk[r_depth - DW'(2)];
    assign o_top   = (r_depth == '0) ? '0 : w_b;
    assign o_depth = r_depth;

`ifdef MATHSOLVER_DIV_EN
    assign w_div_op = (i_opcode == OPC_DIV);
`else
    assign w_div_op = 1'b0;
`endif

    assign w_push  = i_valid && (i_opcode == OPC_PUSH) && (r_depth < DW'(N));
    assign w_binop = i_valid && (r_depth >= DW'(2)) &&
                     ((i_opcode == OPC_ADD) || (i_opcode == OPC_SUB) ||
                      (i_opcode == OPC_MUL) || w_div_op);

    always_comb begin
        w_res = '0;
        case (i_opcode)
            OPC_ADD: w_res = w_a + w_b;
            OPC_SUB: w_res = w_a - w_b;
            OPC_MUL: w_res = w_a * w_b;
`ifdef MATHSOLVER_DIV_EN
            // SV signed division already truncates toward zero
            OPC_DIV: if (w_b != '0) w_res = W'($signed(w_a) / $signed(w_b));
`endif
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_stk[r_depth] <= i_data;
        else if (w_binop)
            r_stk[r_depth - DW'(2)] <= w_res;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || i_clr) begin
            r_depth  <= '0;
            r_in     <= '0;
            r_opc    <= '0;
            r_first  <= '0;
            r_second <= '0;
            r_out    <= '0;
        end else if (w_push) begin
            r_depth  <= r_depth + DW'(1);
            r_in     <= i_data;
            r_opc    <= OPC_PUSH;
            r_first  <= '0;
            r_second <= '0;
            r_out    <= i_data;
        end else if (w_binop) begin
            r_depth  <= r_depth - DW'(1);
            r_in     <= '0;
            r_opc    <= i_opcode;
            r_first  <= w_a;
            r_second <= w_b;
            r_out    <= w_res;
        end
    end

    assign o_input_data  = r_in;
    assign o_opcode      = r_opc;
    assign o_first       = r_first;
    assign o_second      = r_second;
    assign o_output_data = r_out;

endmodule

`default_nettype wire

// File: rtl/math_solver.sv
// ============================================================================
//  Module      : math_solver
//  Description : Shunting-yard infix-to-postfix converter feeding a stack ALU.
//                Macro MATHSOLVER_DIV_EN enables the '/' operator.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module math_solver
    import math_solver_pkg::*;
#(
    parameter int N = 19,
    parameter int W = 16
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      start,
    input  logic [1:0][N-1:0][W-1:0]  infix,
    output logic [1:0][N-1:0][W-1:0]  postfix,
    output logic [W-1:0]              result,
    output logic                      done,
    output logic                      error,
    output logic [W-1:0]              input_data,
    output logic [2:0]                opcode,
    output logic [W-1:0]              first,
    output logic [W-1:0]              second,
    output logic [W-1:0]              output_data
);

    localparam int IW = $clog2(N + 1);
    localparam logic [W-1:0] c_END = W'(TOK_END);
    localparam logic [W-1:0] c_LP  = W'(TOK_LP);
    localparam logic [W-1:0] c_RP  = W'(TOK_RP);
    localparam logic [W-1:0] c_MUL = W'(TOK_MUL);
    localparam logic [W-1:0] c_ADD = W'(TOK_ADD);
    localparam logic [W-1:0] c_SUB = W'(TOK_SUB);

    state_e                    r_state, w_state_nx;
    logic [1:0][N-1:0][W-1:0]  r_infix, r_postfix;
    logic [W-1:0]              r_ops [N];
    logic [IW-1:0]             r_idx, r_osp, r_pf_len;
    logic [W-1:0]              r_result;
    logic                      r_done, r_error;

    logic          w_accept, w_tok_op, w_pf_op, w_top_lp, w_tok_arith;
    logic [W-1:0]  w_tok_val, w_pf_val, w_top, w_app_val, w_alu_top;
    logic          w_adv, w_push, w_pop, w_app, w_app_flag, w_fail, w_finish, w_alu_valid;
    opcode_e       w_alu_opc, w_pf_opc;
    logic [IW-1:0] w_depth;

    assign w_accept  = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start;
    assign w_tok_op  = (r_infix[1][r_idx] != '0);
    assign w_tok_val = r_infix[0][r_idx];
    assign w_pf_op   = (r_postfix[1][r_idx] != '0);
    assign w_pf_val  = r_postfix[0][r_idx];
    assign w_pf_opc  = tok2opc(w_pf_val[7:0]);
    assign w_top     = r_ops[r_osp - IW'(1)];
    assign w_top_lp  = (r_osp != '0) && (w_top == c_LP);

`ifdef MATHSOLVER_DIV_EN
    localparam logic [W-1:0] c_DIV = W'(TOK_DIV);
    assign w_tok_arith = (w_tok_val == c_MUL) || (w_tok_val == c_ADD) ||
                         (w_tok_val == c_SUB) || (w_tok_val == c_DIV);
`else
    assign w_tok_arith = (w_tok_val == c_MUL) || (w_tok_val == c_ADD) ||
                         (w_tok_val == c_SUB);
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= ST_IDLE;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx  = r_state;
        w_adv       = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_app       = 1'b0;
        w_app_flag  = 1'b0;
        w_app_val   = w_tok_val;
        w_fail      = 1'b0;
        w_finish    = 1'b0;
        w_alu_valid = 1'b0;
        w_alu_opc   = OPC_NOP;
        case (r_state)
            ST_IDLE, ST_DONE: if (start) w_state_nx = ST_CONVERT;
            ST_CONVERT: begin
                if (r_idx == IW'(N)) begin
                    w_state_nx = ST_FLUSH;
                end else if (!w_tok_op) begin
                    w_app = 1'b1;
                    w_adv = 1'b1;
                end else if (w_tok_val == c_END) begin
                    w_state_nx = ST_FLUSH;
                end else if (w_tok_val == c_LP) begin
                    w_push = 1'b1;
                    w_adv  = 1'b1;
                end else if (w_tok_val == c_RP) begin
                    // ')' pops one operator per cycle until its '(' is consumed
                    if (r_osp == '0) begin
                        w_fail = 1'b1;
                    end else if (w_top_lp) begin
                        w_pop = 1'b1;
                        w_adv = 1'b1;
                    end else begin
                        w_pop = 1'b1;
                        w_app = 1'b1;
                        w_app_flag = 1'b1;
                        w_app_val  = w_top;
                    end
                end else if (w_tok_arith) begin
                    if ((r_osp != '0) && !w_top_lp &&
                        (prec(w_top[7:0]) >= prec(w_tok_val[7:0]))) begin
                        w_pop = 1'b1;
                        w_app = 1'b1;
                        w_app_flag = 1'b1;
                        w_app_val  = w_top;
                    end else begin
                        w_push = 1'b1;
                        w_adv  = 1'b1;
                    end
                end else begin
                    w_fail = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (r_osp == '0) begin
                    w_state_nx = ST_EVAL;
                end else if (w_top_lp) begin
                    w_fail = 1'b1;
                end else begin
                    w_pop = 1'b1;
                    w_app = 1'b1;
                    w_app_flag = 1'b1;
                    w_app_val  = w_top;
                end
            end
            ST_EVAL: begin
                if (r_idx == r_pf_len) begin
                    if (w_depth == IW'(1)) w_finish = 1'b1;
                    else                   w_fail   = 1'b1;
                end else if (!w_pf_op) begin
                    w_alu_valid = 1'b1;
                    w_alu_opc   = OPC_PUSH;
                    w_adv       = 1'b1;
                end else if (w_depth < IW'(2)) begin
                    w_fail = 1'b1;
                end else if ((w_pf_opc == OPC_DIV) && (w_alu_top == '0)) begin
                    w_fail = 1'b1;
                end else begin
                    w_alu_valid = 1'b1;
                    w_alu_opc   = w_pf_opc;
                    w_adv       = 1'b1;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
        if (w_fail || w_finish) w_state_nx = ST_DONE;
    end

    always_ff @(posedge CLK) begin
        if (w_push) r_ops[r_osp] <= w_tok_val;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_infix   <= '0;
            r_postfix <= '0;
            r_pf_len  <= '0;
            r_idx     <= '0;
            r_osp     <= '0;
            r_result  <= '0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else if (w_accept) begin
            r_infix <= infix;
            for (int k = 0; k < N; k++) begin
                r_postfix[1][k] <= W'(1);
                r_postfix[0][k] <= '0;
            end
            r_pf_len <= '0;
            r_idx    <= '0;
            r_osp    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            if (w_push) r_osp <= r_osp + IW'(1);
            if (w_pop)  r_osp <= r_osp - IW'(1);
            if (w_app) begin
                r_postfix[1][r_pf_len] <= W'(w_app_flag);
                r_postfix[0][r_pf_len] <= w_app_val;
                r_pf_len <= r_pf_len + IW'(1);
            end
            if (w_adv) r_idx <= r_idx + IW'(1);
            if ((r_state == ST_FLUSH) && (w_state_nx == ST_EVAL)) r_idx <= '0;
            if (w_fail) begin
                r_done   <= 1'b1;
                r_error  <= 1'b1;
                r_result <= '0;
            end else if (w_finish) begin
                r_done   <= 1'b1;
                r_result <= w_alu_top;
            end
        end
    end

    stack_alu #(.N(N), .W(W), .DW(IW)) u_alu (
        .clk           (CLK),
        .rst           (RST),
        .i_clr         (w_accept),
        .i_valid       (w_alu_valid),
        .i_opcode      (w_alu_opc),
        .i_data        (w_pf_val),
        .o_depth       (w_depth),
        .o_top         (w_alu_top),
        .o_input_data  (input_data),
        .o_opcode      (opcode),
        .o_first       (first),
        .o_second      (second),
        .o_output_data (output_data)
    );

    assign postfix = r_postfix;
    assign result  = r_result;
    assign done    = r_done;
    assign error   = r_error;

endmodule

`default_nettype wire

// File: tb/tb_math_solver.sv
// ============================================================================
//  Module      : tb_math_solver
//  Description : Self-checking bench for math_solver (scoreboard of expected
//                results). Honours MATHSOLVER_DIV_EN when defined.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_math_solver;

    localparam int N = 19;
    localparam int W = 16;
    localparam int C_LP = 40, C_RP = 41, C_MUL = 42, C_ADD = 43, C_SUB = 45, C_DIV = 47;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [1:0][N-1:0][W-1:0] infix, postfix, exp_pf;
    logic [W-1:0] result, input_data, first, second, output_data;
    logic [2:0]   opcode;
    logic         done, error;

    int checks = 0;
    int errors = 0;
    int ntok, npf;

    typedef struct {
        logic [W-1:0] res;
        logic         err;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    math_solver #(.N(N), .W(W)) dut (
        .CLK         (clk),
        .RST         (rst),
        .start       (start),
        .infix       (infix),
        .postfix     (postfix),
        .result      (result),
        .done        (done),
        .error       (error),
        .input_data  (input_data),
        .opcode      (opcode),
        .first       (first),
        .second      (second),
        .output_data (output_data)
    );

    task automatic new_expr();
        ntok = 0;
        npf  = 0;
        for (int k = 0; k < N; k++) begin
            infix[1][k]  = W'(1);
            infix[0][k]  = '0;
            exp_pf[1][k] = W'(1);
            exp_pf[0][k] = '0;
        end
    endtask

    task automatic opd(input int v);
        infix[1][ntok] = '0;
        infix[0][ntok] = W'(v);
        ntok++;
    endtask

    task automatic opr(input int c);
        infix[1][ntok] = W'(1);
        infix[0][ntok] = W'(c);
        ntok++;
    endtask

    task automatic pf(input logic f, input int v);
        exp_pf[1][npf] = W'(f);
        exp_pf[0][npf] = W'(v);
        npf++;
    endtask

    task automatic expect_result(input int res, input logic err);
        exp_t e;
        e.res = W'(res);
        e.err = err;
        sb.push_back(e);
    endtask

    task automatic run(output int cyc, output bit to);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 1;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        to = !done;
    endtask

    task automatic load_expr1();
        new_expr();
        opd(2); opr(C_MUL); opd(3); opr(C_ADD); opr(C_LP); opd(10); opr(C_ADD); opd(4);
        opr(C_ADD); opd(3); opr(C_RP); opr(C_MUL); opd(-20); opr(C_ADD); opr(C_LP);
        opd(6); opr(C_ADD); opd(5); opr(C_RP);
        pf(0, 2); pf(0, 3); pf(1, C_MUL); pf(0, 10); pf(0, 4); pf(1, C_ADD); pf(0, 3);
        pf(1, C_ADD); pf(0, -20); pf(1, C_MUL); pf(1, C_ADD); pf(0, 6); pf(0, 5);
        pf(1, C_ADD); pf(1, C_ADD);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({done, error} !== 2'b00) begin
            errors++; $display("FAIL reset_flags: done/error=%b required 00", {done, error});
        end
        checks++;
        if (result !== '0 || postfix !== '0) begin
            errors++; $display("FAIL reset_data: result=%h postfix=%h required 0", result, postfix);
        end
        checks++;
        if ({input_data, opcode, first, second, output_data} !== '0) begin
            errors++; $display("FAIL reset_debug: in=%h opc=%b a=%h b=%h out=%h required 0",
                               input_data, opcode, first, second, output_data);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_precedence();
        int cyc; bit to; exp_t e;
        load_expr1();
        expect_result(-323, 1'b0);
        run(cyc, to);
        e = sb.pop_front();
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL prec_timeout: done=%b required 1", done); end
        checks++;
        if (result !== e.res || error !== e.err) begin
            errors++; $display("FAIL prec_result: result=%h error=%b required %h/%b", result, error, e.res, e.err);
        end
        checks++;
        if (postfix !== exp_pf) begin
            errors++; $display("FAIL prec_postfix: got %h required %h", postfix, exp_pf);
        end
        checks++;
        if (cyc > 3 * N + 2) begin
            errors++; $display("FAIL prec_latency: %0d cycles, required <= %0d", cyc, 3 * N + 2);
        end
    endtask

    task automatic test_left_assoc();
        int cyc; bit to; exp_t e;
        new_expr();
        opd(7); opr(C_SUB); opd(2); opr(C_SUB); opd(3);
        pf(0, 7); pf(0, 2); pf(1, C_SUB); pf(0, 3); pf(1, C_SUB);
        expect_result(2, 1'b0);
        run(cyc, to);
        e = sb.pop_front();
        checks++;
        if (to || result !== e.res || error !== e.err) begin
            errors++; $display("FAIL assoc_result: result=%h error=%b to=%b required %h/%b", result, error, to, e.res, e.err);
        end
        checks++;
        if (postfix !== exp_pf) begin
            errors++; $display("FAIL assoc_postfix: got %h required %h", postfix, exp_pf);
        end
        checks++;
        if (opcode !== 3'b010 || first !== W'(5) || second !== W'(3) || output_data !== W'(2)) begin
            errors++; $display("FAIL assoc_debug: opc=%b a=%h b=%h out=%h required 010/0005/0003/0002",
                               opcode, first, second, output_data);
        end
    endtask

    task automatic test_wrap();
        int cyc; bit to; exp_t e;
        new_expr();
        opd(300); opr(C_MUL); opd(300);
        expect_result(16'h5F90, 1'b0);
        run(cyc, to);
        e = sb.pop_front();
        checks++;
        if (to || result !== e.res || error !== e.err) begin
            errors++; $display("FAIL wrap_result: result=%h error=%b required %h/%b", result, error, e.res, e.err);
        end
        checks++;
        if (opcode !== 3'b011 || first !== W'(300) || second !== W'(300) ||
            output_data !== 16'h5F90 || input_data !== '0) begin
            errors++; $display("FAIL wrap_debug: opc=%b a=%h b=%h out=%h in=%h required 011/012c/012c/5f90/0000",
                               opcode, first, second, output_data, input_data);
        end
    endtask

    task automatic test_malformed();
        int cyc; bit to; exp_t e;
        for (int k = 0; k < 6; k++) begin
            new_expr();
            case (k)
                0: begin opr(C_LP); opd(1); opr(C_ADD); opd(2); end
                1: begin opd(1); opr(C_ADD); end
                2: begin opd(1); opr(C_ADD); opd(2); opr(C_RP); end
                4: begin opd(1); opr(37); opd(2); end
                5: begin opd(1); opd(2); end
                default: ;
            endcase
            expect_result(0, 1'b1);
            run(cyc, to);
            e = sb.pop_front();
            checks++;
            if (to || !done || result !== e.res || error !== e.err) begin
                errors++; $display("FAIL malformed_%0d: done=%b result=%h error=%b required 1/%h/%b",
                                   k, done, result, error, e.res, e.err);
            end
        end
    endtask

    task automatic test_div();
        int cyc; bit to; exp_t e;
`ifdef MATHSOLVER_DIV_EN
        new_expr();
        opd(-7); opr(C_DIV); opd(2);
        expect_result(-3, 1'b0);
        run(cyc, to);
        e = sb.pop_front();
        checks++;
        if (to || result !== e.res || error !== e.err) begin
            errors++; $display("FAIL div_trunc: result=%h error=%b required %h/%b", result, error, e.res, e.err);
        end
        new_expr();
        opd(5); opr(C_DIV); opd(0);
        expect_result(0, 1'b1);
        run(cyc, to);
        e = sb.pop_front();
        checks++;
        if (to || result !== e.res || error !== e.err) begin
            errors++; $display("FAIL div_zero: result=%h error=%b required %h/%b", result, error, e.res, e.err);
        end
`else
        new_expr();
        opd(6); opr(C_DIV); opd(2);
        expect_result(0, 1'b1);
        run(cyc, to);
        e = sb.pop_front();
        checks++;
        if (to || result !== e.res || error !== e.err) begin
            errors++; $display("FAIL div_disabled: result=%h error=%b required %h/%b", result, error, e.res, e.err);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int cyc; exp_t e;
        new_expr();
        opd(7); opr(C_SUB); opd(2); opr(C_SUB); opd(3);
        expect_result(2, 1'b0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_clear: done=%b required 0", done); end
        cyc = 1;
        while (!done && cyc < 200) begin @(negedge clk); cyc++; end
        e = sb.pop_front();
        checks++;
        if (!done || result !== e.res || error !== e.err) begin
            errors++; $display("FAIL b2b_result: done=%b result=%h error=%b required 1/%h/%b", done, result, error, e.res, e.err);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done !== 1'b1 || result !== e.res) begin
            errors++; $display("FAIL b2b_hold: done=%b result=%h required 1/%h", done, result, e.res);
        end
    endtask

    task automatic test_start_ignored();
        int cyc; exp_t e;
        load_expr1();
        expect_result(-323, 1'b0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        new_expr();
        opd(300); opr(C_MUL); opd(300);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 6;
        while (!done && cyc < 200) begin @(negedge clk); cyc++; end
        e = sb.pop_front();
        checks++;
        if (!done || result !== e.res || error !== e.err) begin
            errors++; $display("FAIL ignored_start: done=%b result=%h error=%b required 1/%h/%b", done, result, error, e.res, e.err);
        end
    endtask

    task automatic test_reset_mid_eval();
        int cyc; bit to; exp_t e;
        load_expr1();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 1;
        while (opcode !== 3'b110 && cyc < 200) begin @(negedge clk); cyc++; end
        checks++;
        if (opcode !== 3'b110) begin errors++; $display("FAIL mid_eval_reach: opcode=%b required 110", opcode); end
        rst = 1'b1;
        #1;
        checks++;
        if ({done, error, result, input_data, opcode, first, second, output_data} !== '0 || postfix !== '0) begin
            errors++; $display("FAIL mid_eval_reset: done=%b err=%b res=%h in=%h opc=%b a=%h b=%h out=%h pf=%h required 0",
                               done, error, result, input_data, opcode, first, second, output_data, postfix);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        expect_result(-323, 1'b0);
        run(cyc, to);
        e = sb.pop_front();
        checks++;
        if (to || result !== e.res || error !== e.err) begin
            errors++; $display("FAIL after_reset: result=%h error=%b required %h/%b", result, error, e.res, e.err);
        end
    endtask

    initial begin
        new_expr();
        test_reset();
        test_precedence();
        test_left_assoc();
        test_wrap();
        test_malformed();
        test_div();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid_eval();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
